// File: rtl/tmr_pkg.sv
// Shared lane constants, lane vector type and majority helper for the TMR reset voter.
package tmr_pkg;

   localparam int unsigned NUM_LANES = 3;
   localparam int unsigned LANE_A    = 0;
   localparam int unsigned LANE_B    = 1;
   localparam int unsigned LANE_C    = 2;

   typedef logic [NUM_LANES-1:0] lane_vec_t;

   function automatic logic maj3(input lane_vec_t v);
      return (v[LANE_A] & v[LANE_B]) | (v[LANE_A] & v[LANE_C]) | (v[LANE_B] & v[LANE_C]);
   endfunction

endpackage

// File: rtl/tmr_lane_monitor.sv
// Per-lane persistence counter, sticky fault flag and optional mismatch-episode counter.
// Optional episode counter built only when TMR_FAULT_COUNT_EN is defined.
module tmr_lane_monitor
   import tmr_pkg::*;
#(
   parameter int unsigned PERSIST_CYCLES = 4,
   parameter int unsigned CNT_W          = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mism,
   input  logic             fault_clear,
   output logic             flag,
   output logic [CNT_W-1:0] count
);

   localparam int unsigned PW = $clog2(PERSIST_CYCLES + 1);

   logic [PW-1:0] pcnt_q, pcnt_d;
   logic          flag_q, flag_d;
   logic          set_c;

   // Set also fires once saturated, so a clear during an ongoing fault is overridden.
   always_comb begin
      pcnt_d = '0;
      set_c  = 1'b0;
      flag_d = flag_q;
      if (mism) begin
         pcnt_d = (pcnt_q == PW'(PERSIST_CYCLES)) ? pcnt_q : pcnt_q + PW'(1);
         set_c  = (pcnt_q >= PW'(PERSIST_CYCLES - 1));
      end
      if (fault_clear) flag_d = 1'b0;
      if (set_c)       flag_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pcnt_q <= '0;
         flag_q <= 1'b0;
      end else begin
         pcnt_q <= pcnt_d;
         flag_q <= flag_d;
      end
   end

   assign flag = flag_q;

`ifdef TMR_FAULT_COUNT_EN
   logic             mism_prev_q, mism_prev_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // One count per rising edge of the mismatch, saturating at all-ones.
   always_comb begin
      mism_prev_d = mism;
      cnt_d       = cnt_q;
      if (mism && !mism_prev_q && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mism_prev_q <= 1'b0;
         cnt_q       <= '0;
      end else begin
         mism_prev_q <= mism_prev_d;
         cnt_q       <= cnt_d;
      end
   end

   assign count = cnt_q;
`else
   assign count = '0;
`endif

endmodule

// File: rtl/tmr_resetn_voter.sv
// Synchronises three redundant reset lanes, votes 2-of-3 and tracks per-lane persistent faults.
// Per-lane event counters are built only when TMR_FAULT_COUNT_EN is defined.
module tmr_resetn_voter
   import tmr_pkg::*;
#(
   parameter int unsigned SYNC_STAGES    = 2,
   parameter int unsigned PERSIST_CYCLES = 4,
   parameter int unsigned CNT_W          = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_LANES-1:0]         lane_resetn,
   input  logic                         fault_clear,
   output logic                         voted_resetn,
   output logic                         disagreement,
   output logic [NUM_LANES-1:0]         fault_flags,
   output logic [NUM_LANES*CNT_W-1:0]   fault_count
);

   logic [SYNC_STAGES-1:0][NUM_LANES-1:0] sync_q, sync_d;
   lane_vec_t s_c, mism_c;
   logic      voted_q, voted_d;
   logic      dis_q, dis_d;

   // Synchroniser chain: stage 0 samples the raw asynchronous lanes.
   always_comb begin
      sync_d    = '0;
      sync_d[0] = lane_resetn;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
   end

   always_comb begin
      s_c     = sync_q[SYNC_STAGES-1];
      voted_d = maj3(s_c);
      dis_d   = ~(&s_c) & (|s_c);
      mism_c  = s_c ^ {NUM_LANES{voted_d}};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q  <= '0;
         voted_q <= 1'b0;
         dis_q   <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         voted_q <= voted_d;
         dis_q   <= dis_d;
      end
   end

   assign voted_resetn = voted_q;
   assign disagreement = dis_q;

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      tmr_lane_monitor #(
         .PERSIST_CYCLES (PERSIST_CYCLES),
         .CNT_W          (CNT_W)
      ) u_mon (
         .clk         (clk),
         .rst         (rst),
         .mism        (mism_c[i]),
         .fault_clear (fault_clear),
         .flag        (fault_flags[i]),
         .count       (fault_count[i*CNT_W +: CNT_W])
      );
   end

endmodule
